// File: rtl/mdio_pkg.sv
// mdio_pkg: MDIO field widths, queued command record and sequencer state encoding
package mdio_pkg;
  localparam int MDIO_PHY_W = 5;
  localparam int MDIO_REG_W = 5;
  localparam int MDIO_DATA_W = 16;
  typedef struct packed {
    logic                   write;
    logic [MDIO_PHY_W-1:0]  phy_addr;
    logic [MDIO_REG_W-1:0]  reg_addr;
    logic [MDIO_DATA_W-1:0] wdata;
  } mdio_cmd_t;
  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } mdio_seq_state_e;
endpackage

// File: rtl/mdio_sync_fifo.sv
// mdio_sync_fifo: sync FIFO with wrap-bit pointers; push_i/pop_i/din_i in, head_o peek plus full_o/empty_o out
module mdio_sync_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign head_o = mem_q[rd_q[AW-1:0]];
  assign empty_o = wr_q == rd_q;
  assign full_o = wr_q == {~rd_q[AW], rd_q[AW-1:0]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_q + (AW+1)'(push_i);
      rd_q <= rd_q + (AW+1)'(pop_i);
    end
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

// File: rtl/mdio_cmd_sequencer.sv
// mdio_cmd_sequencer: queues MDIO commands (cmd_*), issues them one at a time to mdio_master (mst_*), returns responses (rsp_*)
module mdio_cmd_sequencer
  import mdio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int START_WAIT = 4,
  parameter int DONE_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [MDIO_PHY_W-1:0]  cmd_phy_addr,
  input  logic [MDIO_REG_W-1:0]  cmd_reg_addr,
  input  logic [MDIO_DATA_W-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [MDIO_DATA_W-1:0] rsp_rdata,
  output logic                   rsp_timeout,
  output logic [MDIO_PHY_W-1:0]  mst_phy_addr,
  output logic [MDIO_REG_W-1:0]  mst_reg_addr,
  output logic [MDIO_DATA_W-1:0] mst_data_in,
  output logic                   mst_write_en,
  output logic                   mst_start,
  input  logic                   mst_busy,
  input  logic [MDIO_DATA_W-1:0] mst_rdata,
  output logic                   idle
);
  localparam logic [15:0] START_LIM = 16'(START_WAIT - 1);
  localparam logic [15:0] DONE_LIM = 16'(DONE_TIMEOUT - 1);
  mdio_seq_state_e state_q, state_d;
  mdio_cmd_t head;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic full, empty, pop, load, to_resp, timeout;
  logic mst_start_q, mst_write_en_q;
  logic [MDIO_PHY_W-1:0] mst_phy_q;
  logic [MDIO_REG_W-1:0] mst_reg_q;
  logic [MDIO_DATA_W-1:0] mst_data_q, rsp_rdata_q;
  logic rsp_valid_q, rsp_write_q, rsp_timeout_q;
  assign cmd_ready = !full && !rst;
  assign idle = state_q == S_IDLE && empty;
  assign pop = state_q == S_RESP && rsp_ready;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 16'd1;
  assign load = state_q == S_IDLE && state_d == S_ISSUE;
  assign to_resp = state_q != S_RESP && state_d == S_RESP;
  assign timeout = state_q != S_WAIT_DONE || mst_busy;
  mdio_sync_fifo #(
    .WIDTH($bits(mdio_cmd_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk,
    .rst,
    .push_i(cmd_valid && cmd_ready),
    .pop_i(pop),
    .din_i({cmd_write, cmd_phy_addr, cmd_reg_addr, cmd_wdata}),
    .head_o(head),
    .full_o(full),
    .empty_o(empty)
  );
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      S_IDLE: state_d = !empty && !mst_busy ? S_ISSUE : S_IDLE;
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
        cnt_d = '0;
      end
      S_WAIT_BUSY: begin
        state_d = mst_busy ? S_WAIT_DONE : cnt_q >= START_LIM ? S_RESP : S_WAIT_BUSY;
        cnt_d = mst_busy ? '0 : cnt_inc;
      end
      S_WAIT_DONE: begin
        state_d = !mst_busy || cnt_q >= DONE_LIM ? S_RESP : S_WAIT_DONE;
        cnt_d = cnt_inc;
      end
      S_RESP: state_d = rsp_ready ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      mst_start_q <= 1'b0;
      mst_write_en_q <= 1'b0;
      mst_phy_q <= '0;
      mst_reg_q <= '0;
      mst_data_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      mst_start_q <= load;
      if (load) begin
        mst_write_en_q <= head.write;
        mst_phy_q <= head.phy_addr;
        mst_reg_q <= head.reg_addr;
        mst_data_q <= head.wdata;
      end
      if (to_resp) begin
        rsp_valid_q <= 1'b1;
        rsp_write_q <= mst_write_en_q;
        rsp_timeout_q <= timeout;
        rsp_rdata_q <= timeout || mst_write_en_q ? '0 : mst_rdata;
      end else if (pop) rsp_valid_q <= 1'b0;
    end
  assign mst_start = mst_start_q;
  assign mst_write_en = mst_write_en_q;
  assign mst_phy_addr = mst_phy_q;
  assign mst_reg_addr = mst_reg_q;
  assign mst_data_in = mst_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_mdio_cmd_sequencer.sv
// tb_mdio_cmd_sequencer: directed and random command streams against a queue-based model of expected MDIO responses
module tb_mdio_cmd_sequencer;
  localparam int START_WAIT = 4;
  localparam int DONE_TIMEOUT = 255;
  typedef struct {
    logic        w;
    logic [4:0]  p;
    logic [4:0]  r;
    logic [15:0] d;
    int          beh;
    logic [15:0] rd;
  } txn_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0, mst_busy = 1'b0;
  logic [4:0] cmd_phy_addr = '0, cmd_reg_addr = '0;
  logic [15:0] cmd_wdata = '0, mst_rdata = '0, cur_rd = '0;
  logic cmd_ready, rsp_valid, rsp_write, rsp_timeout, mst_write_en, mst_start, idle;
  logic [15:0] rsp_rdata, mst_data_in;
  logic [4:0] mst_phy_addr, mst_reg_addr;
  int checks = 0, failures = 0, rdy_mode = 1, bcnt = 0;
  txn_t iss_q[$], rsp_q[$];
  txn_t mt, me;
  mdio_cmd_sequencer #(
    .FIFO_DEPTH(4),
    .START_WAIT(START_WAIT),
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_phy_addr(cmd_phy_addr),
    .cmd_reg_addr(cmd_reg_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .mst_phy_addr(mst_phy_addr),
    .mst_reg_addr(mst_reg_addr),
    .mst_data_in(mst_data_in),
    .mst_write_en(mst_write_en),
    .mst_start(mst_start),
    .mst_busy(mst_busy),
    .mst_rdata(mst_rdata),
    .idle(idle)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mst_busy = 1'b0;
      bcnt = 0;
    end else if (mst_start) begin
      chk("start_while_busy", 32'(mst_busy), 32'(0));
      chk("start_has_cmd", 32'(iss_q.size() > 0), 32'(1));
      if (iss_q.size() > 0) begin
        mt = iss_q.pop_front();
        chk("mst_cmd", 32'({mst_write_en, mst_phy_addr, mst_reg_addr, mst_data_in}), 32'({mt.w, mt.p, mt.r, mt.d}));
        cur_rd = mt.rd;
        if (mt.beh != -1) begin
          mst_busy = 1'b1;
          bcnt = mt.beh == -2 ? DONE_TIMEOUT + 45 : mt.beh;
        end
      end
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) begin
        mst_busy = 1'b0;
        mst_rdata = cur_rd;
      end
    end else mst_rdata = ~cur_rd;
  end
  initial forever begin
    @(negedge clk);
    rsp_ready = rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'(rdy_mode == 1);
    if (rsp_valid) begin
      chk("rsp_has_cmd", 32'(rsp_q.size() > 0), 32'(1));
      if (rsp_q.size() > 0) begin
        me = rsp_q[0];
        chk("rsp", 32'({rsp_write, rsp_timeout, rsp_rdata}), 32'({me.w, me.beh < 0, (me.beh < 0 || me.w) ? 16'h0 : me.rd}));
        if (rsp_ready) void'(rsp_q.pop_front());
      end
    end
  end
  task automatic push(input logic w, input logic [4:0] p, input logic [4:0] r, input logic [15:0] d, input int beh, input logic [15:0] rd);
    txn_t t;
    bit acc;
    int n = 0;
    t = '{w, p, r, d, beh, rd};
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_phy_addr = p;
    cmd_reg_addr = r;
    cmd_wdata = d;
    do begin
      acc = cmd_ready;
      @(negedge clk);
      n++;
    end while (!acc && n < 2000);
    chk("push_accept", 32'(acc), 32'(1));
    if (acc) begin
      iss_q.push_back(t);
      rsp_q.push_back(t);
    end
    cmd_valid = 1'b0;
  endtask
  task automatic drain(input string tag);
    int n = 0;
    while (!(rsp_q.size() == 0 && idle && !mst_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < 3000), 32'(1));
  endtask
  initial begin
    #600000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
    chk("rst_flags", 32'({rsp_valid, mst_start, rsp_write, rsp_timeout, mst_write_en}), 32'(0));
    chk("rst_data", 32'({rsp_rdata, mst_data_in}), 32'(0));
    chk("rst_addr", 32'({mst_phy_addr, mst_reg_addr}), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(cmd_ready), 32'(1));
    chk("rel_idle", 32'(idle), 32'(1));
    push(1'b1, 5'd5, 5'd10, 16'hAAAA, 64, 16'h0);
    @(negedge clk);
    chk("wr_issue_lat", 32'(mst_start), 32'(1));
    chk("wr_mst_out", 32'({mst_write_en, mst_data_in}), 32'({1'b1, 16'hAAAA}));
    @(negedge clk);
    chk("start_pulse_width", 32'(mst_start), 32'(0));
    drain("wr_drain");
    push(1'b0, 5'd1, 5'd2, 16'h5555, 12, 16'h1234);
    drain("rd_drain");
    rdy_mode = 0;
    for (int i = 0; i < 4; i++) push(i[0], 5'(i), 5'(i + 3), 16'($urandom), 3 + i, 16'($urandom));
    repeat (20) @(negedge clk);
    chk("full_ready", 32'(cmd_ready), 32'(0));
    chk("full_rsp_held", 32'(rsp_valid), 32'(1));
    rdy_mode = 1;
    push(1'b1, 5'd7, 5'd7, 16'hBEEF, 5, 16'h0);
    drain("bp_drain");
    push(1'b0, 5'd3, 5'd4, 16'h0, -1, 16'h9999);
    @(negedge clk);
    chk("st_issue", 32'(mst_start), 32'(1));
    repeat (START_WAIT) @(negedge clk);
    chk("st_before", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    chk("st_rsp", 32'({rsp_valid, rsp_timeout}), 32'(2'b11));
    push(1'b0, 5'd3, 5'd5, 16'h0, 8, 16'h4321);
    drain("st_drain");
    push(1'b0, 5'd9, 5'd9, 16'h0F0F, -2, 16'hFFFF);
    @(negedge clk);
    chk("dt_issue", 32'(mst_start), 32'(1));
    repeat (DONE_TIMEOUT + 1) @(negedge clk);
    chk("dt_before", 32'(rsp_valid), 32'(0));
    @(negedge clk);
    chk("dt_rsp", 32'({rsp_valid, rsp_timeout, rsp_rdata}), 32'({1'b1, 1'b1, 16'h0}));
    drain("dt_drain");
    push(1'b0, 5'd1, 5'd1, 16'h0, 100, 16'h1111);
    push(1'b1, 5'd2, 5'd2, 16'h2222, 5, 16'h0);
    push(1'b0, 5'd3, 5'd3, 16'h0, 5, 16'h3333);
    repeat (10) @(negedge clk);
    chk("midrst_busy", 32'(mst_busy), 32'(1));
    rst = 1'b1;
    iss_q.delete();
    rsp_q.delete();
    repeat (2) @(negedge clk);
    chk("midrst_ready", 32'(cmd_ready), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_idle", 32'(idle), 32'(1));
    chk("midrst_ready_rel", 32'(cmd_ready), 32'(1));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("midrst_quiet", 32'({mst_start, rsp_valid, idle}), 32'(1));
    end
    push(1'b0, 5'd4, 5'd6, 16'h0, 6, 16'hCAFE);
    drain("midrst_drain");
    rdy_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), $urandom_range(0, 9) == 0 ? -1 : int'($urandom_range(1, 20)), 16'($urandom));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    drain("rand_drain");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
